// File: rtl/pwm_fade_ctrl_if.sv
// Avalon-MM slave port of the PWM fade controller.
// A write or read is a single-cycle strobe. There is no waitrequest, so every strobe is
// accepted on the clk edge where it is high. readdata is valid on the clk after a read
// and holds its value between reads.
interface pwm_fade_ctrl_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, output write, output writedata, output read, input readdata);
  modport slave  (input address, input write, input writedata, input read, output readdata);
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Duty-ramp sequencer in front of one PWM_core. It mirrors the core's frame counter and
// updates the core's period and pulse width only on frame ticks.
module pwm_fade_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  pwm_fade_ctrl_if.slave        bus,
  output logic [8:0]            period_out,
  output logic [7:0]            pulse_width_out,
  output logic [3:0]            byteenable_out,
  output logic                  busy,
  output logic                  irq,
  output logic [1:0]            fsm_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  logic [1:0]  state;
  logic        loop_en;
  logic        irq_en;
  logic [8:0]  period_reg;
  logic [7:0]  target;
  logic [7:0]  step_reg;
  logic [15:0] dwell_reg;
  logic [7:0]  duty;
  logic        done;
  logic [7:0]  dest;
  logic        dest_zero;
  logic [15:0] dwell_cnt;
  logic [7:0]  frame_cnt;
  logic [31:0] readdata_q;

  logic        wr_ctrl;
  logic        start_p;
  logic        abort_p;
  logic        clr_done;
  logic        step_fire;
  logic        set_done;
  logic [7:0]  eff_period;
  logic        frame_tick;
  logic [8:0]  step_s;
  logic [8:0]  up_sum;
  logic [8:0]  down_diff;
  logic [7:0]  new_duty;
  logic [15:0] dwell_load;

  assign wr_ctrl  = bus.write && (bus.address == 2'd0);
  assign abort_p  = wr_ctrl && bus.writedata[2];
  assign start_p  = wr_ctrl && bus.writedata[0] && !bus.writedata[2];
  assign clr_done = bus.write && (bus.address == 2'd3) && bus.writedata[9];

  assign busy      = (state != ST_IDLE);
  assign irq       = done & irq_en;
  assign fsm_state = state;

  // The core counter is only 8 bits wide, so the programmed period is clamped to 1..255.
  always_comb begin
    if (period_reg == 9'd0)
      eff_period = 8'd1;
    else if (period_reg > 9'd255)
      eff_period = 8'd255;
    else
      eff_period = period_reg[7:0];
  end

  assign frame_tick = (frame_cnt == eff_period);

  assign step_s     = (step_reg == 8'd0) ? 9'd1 : {1'b0, step_reg};
  assign up_sum     = {1'b0, duty} + step_s;
  assign down_diff  = {1'b0, duty} - step_s;
  assign dwell_load = (dwell_reg == 16'd0) ? 16'd1 : dwell_reg;

  // The next duty value saturates at dest in either direction and never wraps.
  always_comb begin
    new_duty = duty;
    if (duty < dest) begin
      if (up_sum >= {1'b0, dest})
        new_duty = dest;
      else
        new_duty = up_sum[7:0];
    end else if (duty > dest) begin
      if (step_s >= ({1'b0, duty} - {1'b0, dest}))
        new_duty = dest;
      else
        new_duty = down_diff[7:0];
    end
  end

  assign step_fire = (state == ST_STEP) && !abort_p && !start_p;
  assign set_done  = step_fire && (new_duty == dest) && !loop_en;

  // Register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loop_en    <= 1'b0;
      irq_en     <= 1'b0;
      period_reg <= 9'd255;
      target     <= 8'd0;
      step_reg   <= 8'd0;
      dwell_reg  <= 16'd0;
    end else if (bus.write) begin
      case (bus.address)
        2'd0: begin
          loop_en <= bus.writedata[1];
          irq_en  <= bus.writedata[3];
        end
        2'd1: period_reg <= bus.writedata[8:0];
        2'd2: begin
          target    <= bus.writedata[7:0];
          step_reg  <= bus.writedata[15:8];
          dwell_reg <= bus.writedata[31:16];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_q <= 32'd0;
    end else if (bus.read) begin
      case (bus.address)
        2'd0:    readdata_q <= {28'd0, irq_en, 1'b0, loop_en, 1'b0};
        2'd1:    readdata_q <= {23'd0, period_reg};
        2'd2:    readdata_q <= {dwell_reg, step_reg, target};
        default: readdata_q <= {22'd0, done, busy, duty};
      endcase
    end
  end

  assign bus.readdata = readdata_q;

  // Sequencer; abort beats start, and both beat whatever the FSM would do this clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      duty      <= 8'd0;
      dest      <= 8'd0;
      dest_zero <= 1'b0;
      dwell_cnt <= 16'd0;
    end else if (abort_p) begin
      state <= ST_IDLE;
    end else if (start_p) begin
      state     <= ST_WAIT;
      dwell_cnt <= dwell_load;
      dest      <= target;
      dest_zero <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (frame_tick) begin
            dwell_cnt <= dwell_cnt - 16'd1;
            if (dwell_cnt <= 16'd1)
              state <= ST_STEP;
          end
        end
        ST_STEP: begin
          duty <= new_duty;
          if (new_duty != dest) begin
            state     <= ST_WAIT;
            dwell_cnt <= dwell_load;
          end else if (loop_en) begin
            dest      <= dest_zero ? target : 8'd0;
            dest_zero <= !dest_zero;
            state     <= ST_WAIT;
            dwell_cnt <= dwell_load;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      done <= 1'b0;
    else if (set_done)
      done <= 1'b1;
    else if (clr_done)
      done <= 1'b0;
  end

  // Frame mirror and shadow outputs: the core only ever sees whole frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt       <= 8'd1;
      period_out      <= 9'd0;
      pulse_width_out <= 8'd0;
      byteenable_out  <= 4'b0000;
    end else begin
      byteenable_out <= 4'b0001;
      if (frame_tick) begin
        frame_cnt       <= 8'd1;
        period_out      <= {1'b0, eff_period};
        pulse_width_out <= duty;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: ramps, loop/abort, clamping, irq and reset behaviour.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] period_out;
  logic [7:0] pulse_width_out;
  logic [3:0] byteenable_out;
  logic       busy;
  logic       irq;
  logic [1:0] fsm_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [7:0] seen_v [0:15];
  int         seen_t [0:15];
  int         seen_n;

  pwm_fade_ctrl_if bus ();

  pwm_fade_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .period_out      (period_out),
    .pulse_width_out (pulse_width_out),
    .byteenable_out  (byteenable_out),
    .busy            (busy),
    .irq             (irq),
    .fsm_state       (fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clk);
    bus.read    = 1'b0;
    d = bus.readdata;
  endtask

  task automatic wait_period_out(input logic [8:0] v, input int bound, output int n);
    n = 0;
    while (period_out !== v && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (period_out !== v) n = -1;
  endtask

  task automatic collect_changes(input int want, input int bound);
    logic [7:0] last;
    int k;
    last   = pulse_width_out;
    seen_n = 0;
    k      = 0;
    while (seen_n < want && k < bound) begin
      @(negedge clk);
      k++;
      if (pulse_width_out !== last) begin
        if (seen_n < 16) begin
          seen_v[seen_n] = pulse_width_out;
          seen_t[seen_n] = cyc;
        end
        seen_n++;
        last = pulse_width_out;
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    logic [31:0] rd;
    int n;
    reset = 1'b0;
    bus.address = 2'd0; bus.write = 1'b0; bus.writedata = 32'd0; bus.read = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (period_out !== 9'd0) begin err_cnt++; $display("FAIL rst_period: got %0d want 0", period_out); end
    vec_cnt++; if (pulse_width_out !== 8'd0) begin err_cnt++; $display("FAIL rst_pw: got %0d want 0", pulse_width_out); end
    vec_cnt++; if (byteenable_out !== 4'd0) begin err_cnt++; $display("FAIL rst_be: got %0d want 0", byteenable_out); end
    vec_cnt++; if (busy !== 1'b0 || irq !== 1'b0) begin err_cnt++; $display("FAIL rst_busy_irq: got %b%b want 00", busy, irq); end
    vec_cnt++; if (fsm_state !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
    reset = 1'b1;
    @(negedge clk);
    vec_cnt++; if (byteenable_out !== 4'd1) begin err_cnt++; $display("FAIL be_after_release: got %0d want 1", byteenable_out); end
    wait_period_out(9'd255, 400, n);
    vec_cnt++; if (n !== 254) begin err_cnt++; $display("FAIL first_tick: got %0d more clks want 254", n); end
    bus_read(2'd1, rd);
    vec_cnt++; if (rd !== 32'd255) begin err_cnt++; $display("FAIL rd_period_rst: got %0h want ff", rd); end
    bus_read(2'd3, rd);
    vec_cnt++; if (rd !== 32'd0) begin err_cnt++; $display("FAIL rd_status_rst: got %0h want 0", rd); end
  endtask

  task automatic test_single_ramp();
    logic [31:0] rd;
    logic [7:0]  exp_v [4];
    int n;
    exp_v = '{8'd64, 8'd128, 8'd192, 8'd200};
    bus_write(2'd1, 32'd10);
    wait_period_out(9'd10, 600, n);
    vec_cnt++; if (n < 0) begin err_cnt++; $display("FAIL period10: got %0d want 10", period_out); end
    bus_write(2'd2, 32'h0002_40C8);
    bus_write(2'd0, 32'h1);
    vec_cnt++; if (busy !== 1'b1 || fsm_state !== 2'd1) begin err_cnt++; $display("FAIL start_busy: got busy %b state %0d want 1 1", busy, fsm_state); end
    collect_changes(4, 300);
    vec_cnt++; if (seen_n !== 4) begin err_cnt++; $display("FAIL ramp_count: got %0d want 4", seen_n); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (seen_v[i] !== exp_v[i]) begin err_cnt++; $display("FAIL ramp_val[%0d]: got %0d want %0d", i, seen_v[i], exp_v[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      vec_cnt++; if (seen_t[i] - seen_t[i-1] !== 20) begin err_cnt++; $display("FAIL ramp_gap[%0d]: got %0d want 20", i, seen_t[i] - seen_t[i-1]); end
    end
    repeat (3) @(negedge clk);
    vec_cnt++; if (busy !== 1'b0 || irq !== 1'b0) begin err_cnt++; $display("FAIL ramp_end: got busy %b irq %b want 0 0", busy, irq); end
    bus_read(2'd3, rd);
    vec_cnt++; if (rd !== 32'h2C8) begin err_cnt++; $display("FAIL ramp_status: got %0h want 2c8", rd); end
    bus_write(2'd3, 32'h200);
    bus_read(2'd3, rd);
    vec_cnt++; if (rd !== 32'h0C8) begin err_cnt++; $display("FAIL done_clear: got %0h want c8", rd); end
  endtask

  task automatic test_down_step0();
    logic [31:0] rd;
    bus_write(2'd2, 32'h0001_00C3);
    bus_write(2'd0, 32'h1);
    collect_changes(5, 300);
    vec_cnt++; if (seen_n !== 5) begin err_cnt++; $display("FAIL down_count: got %0d want 5", seen_n); end
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if (seen_v[i] !== 8'(199 - i)) begin err_cnt++; $display("FAIL down_val[%0d]: got %0d want %0d", i, seen_v[i], 199 - i); end
    end
    vec_cnt++; if (seen_t[4] - seen_t[3] !== 10) begin err_cnt++; $display("FAIL down_gap: got %0d want 10", seen_t[4] - seen_t[3]); end
    repeat (40) @(negedge clk);
    vec_cnt++; if (pulse_width_out !== 8'd195) begin err_cnt++; $display("FAIL down_hold: got %0d want 195", pulse_width_out); end
    bus_read(2'd3, rd);
    vec_cnt++; if (rd !== 32'h2C3) begin err_cnt++; $display("FAIL down_status: got %0h want 2c3", rd); end
    bus_write(2'd3, 32'h200);
  endtask

  task automatic test_loop_abort();
    logic [31:0] rd;
    logic [7:0]  exp_v [7];
    exp_v = '{8'd145, 8'd100, 8'd50, 8'd0, 8'd50, 8'd100, 8'd50};
    bus_write(2'd2, 32'h0003_3264);
    bus_write(2'd0, 32'h3);
    collect_changes(7, 600);
    vec_cnt++; if (seen_n !== 7) begin err_cnt++; $display("FAIL loop_count: got %0d want 7", seen_n); end
    for (int i = 0; i < 7; i++) begin
      vec_cnt++; if (seen_v[i] !== exp_v[i]) begin err_cnt++; $display("FAIL loop_val[%0d]: got %0d want %0d", i, seen_v[i], exp_v[i]); end
    end
    vec_cnt++; if (seen_t[6] - seen_t[5] !== 30) begin err_cnt++; $display("FAIL loop_gap: got %0d want 30", seen_t[6] - seen_t[5]); end
    bus_write(2'd0, 32'h4);
    vec_cnt++; if (busy !== 1'b0 || fsm_state !== 2'd0) begin err_cnt++; $display("FAIL abort_idle: got busy %b state %0d want 0 0", busy, fsm_state); end
    repeat (100) @(negedge clk);
    vec_cnt++; if (pulse_width_out !== 8'd50) begin err_cnt++; $display("FAIL abort_frozen: got %0d want 50", pulse_width_out); end
    bus_read(2'd3, rd);
    vec_cnt++; if (rd !== 32'h032) begin err_cnt++; $display("FAIL abort_status: got %0h want 32", rd); end
  endtask

  task automatic test_clamp_irq();
    logic [31:0] rd;
    int n;
    bus_write(2'd1, 32'd300);
    wait_period_out(9'd255, 600, n);
    vec_cnt++; if (period_out !== 9'd255) begin err_cnt++; $display("FAIL clamp_hi: got %0d want 255", period_out); end
    bus_read(2'd1, rd);
    vec_cnt++; if (rd !== 32'd300) begin err_cnt++; $display("FAIL rd_period300: got %0d want 300", rd); end
    bus_write(2'd1, 32'd0);
    wait_period_out(9'd1, 600, n);
    vec_cnt++; if (period_out !== 9'd1) begin err_cnt++; $display("FAIL clamp_lo: got %0d want 1", period_out); end
    bus_write(2'd2, 32'h0001_0034);
    vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_pre: got %b want 0", irq); end
    bus_write(2'd0, 32'h9);
    collect_changes(2, 50);
    vec_cnt++; if (seen_n !== 2 || seen_v[0] !== 8'd51 || seen_v[1] !== 8'd52) begin err_cnt++; $display("FAIL p1_vals: got n=%0d %0d %0d want 2 51 52", seen_n, seen_v[0], seen_v[1]); end
    vec_cnt++; if (seen_t[1] - seen_t[0] !== 2) begin err_cnt++; $display("FAIL p1_gap: got %0d want 2", seen_t[1] - seen_t[0]); end
    vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_rise: got %b want 1", irq); end
    bus_write(2'd3, 32'h200);
    vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_fall: got %b want 0", irq); end
    // done set by STEP and cleared by a STATUS write on the same edge
    bus_write(2'd2, 32'h0001_0035);
    @(negedge clk);
    bus.address = 2'd0; bus.writedata = 32'h9; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    @(negedge clk);
    bus.address = 2'd3; bus.writedata = 32'h200; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    bus_read(2'd3, rd);
    vec_cnt++; if (rd !== 32'h235) begin err_cnt++; $display("FAIL set_wins: got %0h want 235", rd); end
    vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL set_wins_irq: got %b want 1", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int n;
    int bad;
    bus_write(2'd1, 32'd10);
    wait_period_out(9'd10, 600, n);
    bus_write(2'd2, 32'h0005_0AC8);
    bus_write(2'd0, 32'h9);
    repeat (15) @(negedge clk);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL mid_busy: got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    vec_cnt++; if (period_out !== 9'd0 || pulse_width_out !== 8'd0) begin err_cnt++; $display("FAIL mid_rst_out: got %0d %0d want 0 0", period_out, pulse_width_out); end
    vec_cnt++; if (byteenable_out !== 4'd0 || busy !== 1'b0 || irq !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_ctl: got be %0d busy %b irq %b want 0 0 0", byteenable_out, busy, irq); end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || pulse_width_out !== 8'd0) bad++;
    end
    vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL post_rst_quiet: got %0d active clks want 0", bad); end
    vec_cnt++; if (period_out !== 9'd255) begin err_cnt++; $display("FAIL post_rst_period: got %0d want 255", period_out); end
    bus_read(2'd2, rd);
    vec_cnt++; if (rd !== 32'd0) begin err_cnt++; $display("FAIL post_rst_ramp: got %0h want 0", rd); end
    bus_read(2'd0, rd);
    vec_cnt++; if (rd !== 32'd0) begin err_cnt++; $display("FAIL post_rst_ctrl: got %0h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_single_ramp();
    test_down_step0();
    test_loop_abort();
    test_clamp_irq();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Sequencing controller that sits between the Qsys/Avalon-MM bus and one `PWM_core` instance. It owns the core's `period`, `pulse_width` and `byteenable` inputs. It ramps the duty value from its current level toward a programmed target in programmable steps, one step every N PWM frames, with optional 0↔target ping-pong looping. All duty and period changes are applied only at PWM frame boundaries, so the LED output never sees a torn frame.

## Interface
- No parameters. Widths are fixed: duty 8 bits, period 9 bits, bus 32 bits.
- `clk` in 1 — system clock, shared with `PWM_core`.
- `reset` in 1 — asynchronous, active-low.
- `address` in 2 — register select.
- `write` in 1 — bus write strobe.
- `writedata` in 32 — bus write data.
- `read` in 1 — bus read strobe.
- `readdata` out 32 — registered read data.
- `period_out` out 9 — to core `period`.
- `pulse_width_out` out 8 — to core `pulse_width`.
- `byteenable_out` out 4 — to core `byteenable`.
- `busy` out 1 — high while a ramp is active.
- `irq` out 1 — level interrupt: `done` AND `irq_en`.

## Operation
- **Registers:**
  - addr0 CTRL: bit0 `start` (write-1 pulse, reads 0), bit1 `loop`, bit2 `abort` (write-1 pulse), bit3 `irq_en`.
  - addr1 PERIOD: [8:0].
  - addr2 RAMP: [7:0] `target`, [15:8] `step`, [31:16] `dwell` (frames per step).
  - addr3 STATUS: [7:0] current duty, bit8 `busy`, bit9 `done` (sticky; write 1 to clear). Writes to other STATUS bits are ignored.
- **Register reset values:** CTRL 0, PERIOD 255, RAMP 0, duty 0, `done` 0.
- **Period clamp:** effective period = clamp(PERIOD, 1, 255), since the core counter is 8 bits.
- **Frame mirror:** internal 8-bit counter, reset to 1. It increments each clk and reloads 1 when equal to the effective period, matching the core's counter exactly. The reload cycle is the frame tick.
- **Shadow update:** at each frame tick, `period_out` ← effective period and `pulse_width_out` ← duty. Neither changes at any other time.
- **`byteenable_out`:** 4'b0000 in reset, 4'b0001 from the first clk after reset release.
- **FSM states:** IDLE, WAIT, STEP.
  - IDLE: `busy`=0. `start` → WAIT; load dwell counter with max(`dwell`,1); `dest` = `target`.
  - WAIT: decrement the dwell counter on each frame tick. When it reaches 0 → STEP.
  - STEP (one clk):
    - If duty < `dest`: duty ← min(duty + s, `dest`).
    - If duty > `dest`: duty ← max(duty − s, `dest`).
    - s = max(`step`,1). Arithmetic is done 9-bit, with no wrap.
    - If the new duty ≠ `dest` → WAIT (reload dwell).
    - If the new duty = `dest` and `loop`=1: `dest` toggles between `target` and 0 → WAIT.
    - If the new duty = `dest` and `loop`=0: set `done` → IDLE.
  - Start with duty already equal to `target` and `loop`=0: WAIT runs once, then STEP sets `done`.
- **Live RAMP writes:** `step`, `dwell` and `target` written while busy take effect at the next STEP/reload. `dest` is re-evaluated from `target` only on `start` or a loop toggle.
- **`start` while busy:** restarts from the current duty. The dwell counter is reloaded and `dest` = `target`.
- **`abort`:** → IDLE next clk. Duty holds and `done` is not set. `abort` wins over `start` in the same write.
- **`done` set and clear in the same clk:** set wins.

## Timing
- `readdata` is valid the clk after `read` (1-cycle latency). It holds its value when not reading.
- A register write takes effect on the clk edge where `write`=1.
- `start` → `busy`=1 on the next clk.
- First duty change: `dwell` frame ticks after `start`, plus 1 clk (STEP). It reaches `pulse_width_out` at the following frame tick.
- `irq` rises 1 clk after STEP sets `done`. It falls 1 clk after the clear write, or when `irq_en` is cleared.
- Reset mid-ramp: all outputs return to reset values asynchronously. The FSM returns to IDLE.

## Test plan
- **Reset values:** assert reset → `period_out`=0, `pulse_width_out`=0, `byteenable_out`=0, `busy`=0, `irq`=0. Release reset → `byteenable_out`=1 next clk; `period_out`=255 at the first frame tick.
- **Single ramp:** PERIOD=10, RAMP{dwell=2, step=64, target=200}, start → `pulse_width_out` is 64, 128, 192, 200, each change exactly 20 clks apart, applied only on frame ticks. Then `done`=1 and `busy`=0.
- **Downward ramp with step 0:** from duty=200, target=195, step=0 → duty steps by 1 to 195. Never undershoots.
- **Loop:** `loop`=1, target=100, step=50 → duty sequence 50, 100, 50, 0, 50, … `done` never sets. `abort` → `busy`=0 and duty frozen.
- **Clamping and irq:**
  - PERIOD=300 → `period_out`=255.
  - PERIOD=0 → `period_out`=1, frame tick every clk.
  - `irq_en`=1: `irq` rises after `done` is set.
  - Same-clk `done` set and STATUS clear → `done` stays 1.
- **Reset mid-ramp:** assert reset during WAIT → all outputs reset immediately. After release, no ramp activity until a new `start`.
